// File: rtl/axis_in_pkg.sv
// axis_in_pkg: shared types and helpers for the AXI-Stream ingress block.
// Provides the ingress FSM state encoding (IDLE/RUN/DRAIN, 2-bit) and a
// constant clog2 used to size FIFO pointers and the level output.
package axis_in_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  // Ceiling log2, usable in parameter/port width expressions.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int v = 1; v < n; v = v * 2) r++;
    return r;
  endfunction

endpackage

// File: rtl/axis_sync_fifo.sv
// axis_sync_fifo: pDEPTH-entry synchronous FIFO with first-word fall-through head.
// Ports: push_i/wdat_i write side, pop_i/rdat_o read side, full_o/empty_o/level_o status.
// Head data reads as zero while empty so downstream sees clean outputs after reset.
module axis_sync_fifo
  import axis_in_pkg::*;
#(
  parameter int pWIDTH = 33,
  parameter int pDEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push_i,
  input  logic [pWIDTH-1:0]        wdat_i,
  input  logic                     pop_i,
  output logic [pWIDTH-1:0]        rdat_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [clog2(pDEPTH):0]   level_o
);

  localparam int AW = clog2(pDEPTH);

  // One extra pointer bit distinguishes full from empty when the indices match.
  logic [AW:0]       wr_ptr_q;
  logic [AW:0]       rd_ptr_q;
  logic [pWIDTH-1:0] mem_q [pDEPTH];
  logic              wr_en;
  logic              rd_en;

  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign level_o = wr_ptr_q - rd_ptr_q;
  assign rdat_o  = empty_o ? '0 : mem_q[rd_ptr_q[AW-1:0]];

  // A full FIFO never accepts, even if the head pops in the same cycle.
  assign wr_en = push_i && !full_o;
  assign rd_en = pop_i && !empty_o;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (wr_en) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (rd_en) rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  // Storage is not reset; reset empties the FIFO through the pointers.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q[AW-1:0]] <= wdat_i;
  end

endmodule

// File: rtl/axis_in_fifo.sv
// axis_in_fifo: AXI-Stream ingress for the FIR dataflow. Buffers {tlast,tdata} in a
// pDEPTH FIFO and presents a valid/ready stream (m_*) to the FIR core; tracks a frame
// from ap_start to the last-sample pop (axis_finish), with sample_cnt and fifo_level.
// Ports: clk/rst_n, ap_start, data_length, s_t* slave, m_* master, axis_finish,
// sample_cnt, fifo_level, len_err.
// Optional frame-length check enabled by defining AXIS_IN_LEN_CHECK_EN.
module axis_in_fifo
  import axis_in_pkg::*;
#(
  parameter int pDATA_WIDTH = 32,
  parameter int pDEPTH      = 4,
  parameter int pCNT_WIDTH  = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   ap_start,
  input  logic [pCNT_WIDTH-1:0]  data_length,
  input  logic                   s_tvalid,
  input  logic [pDATA_WIDTH-1:0] s_tdata,
  input  logic                   s_tlast,
  output logic                   s_tready,
  output logic                   m_valid,
  output logic [pDATA_WIDTH-1:0] m_data,
  output logic                   m_last,
  input  logic                   m_ready,
  output logic                   axis_finish,
  output logic [pCNT_WIDTH-1:0]  sample_cnt,
  output logic [clog2(pDEPTH):0] fifo_level,
  output logic                   len_err
);

  state_t                  state_q;
  logic [pCNT_WIDTH-1:0]   sample_cnt_q;
  logic [pCNT_WIDTH-1:0]   sample_cnt_d;
  logic                    axis_finish_q;
  logic                    fifo_full;
  logic                    fifo_empty;
  logic                    push;
  logic                    pop;
  logic                    last_eff;
  logic [pDATA_WIDTH:0]    head;

  // Ready depends only on registered state, never on m_ready.
  assign s_tready = (state_q == RUN) && !fifo_full;
  assign push     = s_tvalid && s_tready;
  assign pop      = m_valid && m_ready;

  assign sample_cnt_d = (&sample_cnt_q) ? sample_cnt_q : sample_cnt_q + 1'b1;

`ifdef AXIS_IN_LEN_CHECK_EN
  logic                  len_err_q;
  logic [pCNT_WIDTH:0]   cnt_next;
  logic                  short_frame;
  logic                  len_reached;

  // Widened so a saturated counter cannot wrap into a false comparison.
  assign cnt_next    = {1'b0, sample_cnt_q} + 1'b1;
  assign short_frame = s_tlast && (cnt_next < {1'b0, data_length});
  // Reaching the programmed length without tlast truncates the frame here.
  assign len_reached = !s_tlast && (cnt_next == {1'b0, data_length});
  assign last_eff    = s_tlast || len_reached;
  assign len_err     = len_err_q;
`else
  logic unused_data_length;
  assign unused_data_length = ^data_length;
  assign last_eff = s_tlast;
  assign len_err  = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      sample_cnt_q  <= '0;
      axis_finish_q <= 1'b0;
`ifdef AXIS_IN_LEN_CHECK_EN
      len_err_q     <= 1'b0;
`endif
    end else begin
      axis_finish_q <= pop && m_last;
      case (state_q)
        IDLE: begin
          if (ap_start) begin
            state_q      <= RUN;
            sample_cnt_q <= '0;
`ifdef AXIS_IN_LEN_CHECK_EN
            len_err_q    <= 1'b0;
`endif
          end
        end
        RUN: begin
          if (push) begin
            sample_cnt_q <= sample_cnt_d;
            if (last_eff) state_q <= DRAIN;
`ifdef AXIS_IN_LEN_CHECK_EN
            if (short_frame || len_reached) len_err_q <= 1'b1;
`endif
          end
        end
        DRAIN: begin
          if (pop && m_last) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  axis_sync_fifo #(
    .pWIDTH (pDATA_WIDTH + 1),
    .pDEPTH (pDEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (push),
    .wdat_i  ({last_eff, s_tdata}),
    .pop_i   (pop),
    .rdat_o  (head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .level_o (fifo_level)
  );

  assign m_valid     = !fifo_empty;
  assign m_last      = head[pDATA_WIDTH];
  assign m_data      = head[pDATA_WIDTH-1:0];
  assign axis_finish = axis_finish_q;
  assign sample_cnt  = sample_cnt_q;

endmodule

// File: tb/tb_axis_in_fifo.sv
module tb_axis_in_fifo;

  localparam int DW = 32;
  localparam int D  = 4;
  localparam int CW = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          ap_start = 1'b0;
  logic [CW-1:0] data_length = '0;
  logic          s_tvalid = 1'b0;
  logic [DW-1:0] s_tdata = '0;
  logic          s_tlast = 1'b0;
  logic          s_tready;
  logic          m_valid;
  logic [DW-1:0] m_data;
  logic          m_last;
  logic          m_ready = 1'b0;
  logic          axis_finish;
  logic [CW-1:0] sample_cnt;
  logic [2:0]    fifo_level;
  logic          len_err;

  axis_in_fifo #(.pDATA_WIDTH(DW), .pDEPTH(D), .pCNT_WIDTH(CW)) dut (
    .clk(clk), .rst_n(rst_n), .ap_start(ap_start), .data_length(data_length),
    .s_tvalid(s_tvalid), .s_tdata(s_tdata), .s_tlast(s_tlast), .s_tready(s_tready),
    .m_valid(m_valid), .m_data(m_data), .m_last(m_last), .m_ready(m_ready),
    .axis_finish(axis_finish), .sample_cnt(sample_cnt), .fifo_level(fifo_level),
    .len_err(len_err)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  bit cmp_en = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // phase: 0 = waiting for start, 1 = accepting, 2 = waiting for last pop
  logic [DW:0]   mq[$];
  int            m_phase = 0;
  logic [CW-1:0] m_cnt = '0;
  logic          m_err = 1'b0;
  logic          m_fin = 1'b0;
  int            m_push_n = 0;

  function automatic bit exp_rdy();
    return (m_phase == 1) && (mq.size() < D);
  endfunction

  always @(posedge clk or negedge rst_n) begin : mdl
    bit   pop_e, push_e, head_last, lastb, err_e;
    if (!rst_n) begin
      mq.delete();
      m_phase <= 0;
      m_cnt   <= '0;
      m_err   <= 1'b0;
      m_fin   <= 1'b0;
    end else begin
      pop_e     = (mq.size() > 0) && m_ready;
      head_last = (mq.size() > 0) && mq[0][DW];
      push_e    = s_tvalid && exp_rdy();
      lastb     = s_tlast;
      err_e     = 1'b0;
`ifdef AXIS_IN_LEN_CHECK_EN
      if (push_e && s_tlast && (int'(m_cnt) + 1 < int'(data_length))) err_e = 1'b1;
      if (push_e && !s_tlast && (int'(m_cnt) + 1 == int'(data_length))) begin
        err_e = 1'b1;
        lastb = 1'b1;
      end
`endif
      m_fin <= pop_e && head_last;
      if (pop_e) void'(mq.pop_front());
      if (push_e) begin
        mq.push_back({lastb, s_tdata});
        m_push_n <= m_push_n + 1;
        if (m_cnt != {CW{1'b1}}) m_cnt <= m_cnt + 1'b1;
        if (err_e) m_err <= 1'b1;
        if (lastb) m_phase <= 2;
      end
      if (m_phase == 0 && ap_start) begin
        m_phase <= 1;
        m_cnt   <= '0;
        m_err   <= 1'b0;
      end
      if (m_phase == 2 && pop_e && head_last) m_phase <= 0;
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (cmp_en && rst_n) begin
      chk("s_tready", 64'(s_tready), 64'(exp_rdy()));
      chk("m_valid", 64'(m_valid), 64'(mq.size() > 0));
      chk("fifo_level", 64'(fifo_level), 64'(mq.size()));
      chk("sample_cnt", 64'(sample_cnt), 64'(m_cnt));
      chk("axis_finish", 64'(axis_finish), 64'(m_fin));
      chk("len_err", 64'(len_err), 64'(m_err));
      if (mq.size() > 0) begin
        chk("m_data", 64'(m_data), 64'(mq[0][DW-1:0]));
        chk("m_last", 64'(m_last), 64'(mq[0][DW]));
      end
    end
  end

  // ---------------- output monitor ----------------
  logic [DW:0] rxq[$];
  int          fin_cnt = 0;

  always @(posedge clk) begin
    if (rst_n) begin
      if (m_valid && m_ready) rxq.push_back({m_last, m_data});
      if (axis_finish) fin_cnt++;
    end
  end

  // ---------------- driver helpers (called at a negedge) ----------------
  task automatic pulse_start();
    ap_start = 1'b1;
    @(negedge clk);
    ap_start = 1'b0;
  endtask

  task automatic send(input logic [DW-1:0] d, input logic l);
    int n0;
    int k;
    n0 = m_push_n;
    k = 0;
    s_tvalid = 1'b1;
    s_tdata  = d;
    s_tlast  = l;
    while (m_push_n == n0 && k < 50) begin
      @(negedge clk);
      k++;
    end
    if (m_push_n == n0) chk("send_timeout", 64'(k), 64'(0));
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
  endtask

  task automatic wait_idle();
    int k;
    k = 0;
    while ((m_phase != 0 || mq.size() != 0) && k < 100) begin
      @(negedge clk);
      k++;
    end
    if (k >= 100) chk("drain_timeout", 64'(k), 64'(0));
    repeat (2) @(negedge clk);
  endtask

  // Expects n beats base..base+n-1, last flag only on the final one.
  task automatic check_rx(input string name, input int base, input int n);
    chk({name, "_count"}, 64'(rxq.size()), 64'(n));
    for (int i = 0; i < n && i < rxq.size(); i++)
      chk({name, "_beat"}, 64'(rxq[i]), {31'd0, (i == n - 1), 32'(base + i)});
  endtask

  task automatic check_all_zero(input string name);
    chk({name, "_s_tready"}, 64'(s_tready), 64'(0));
    chk({name, "_m_valid"}, 64'(m_valid), 64'(0));
    chk({name, "_m_data"}, 64'(m_data), 64'(0));
    chk({name, "_m_last"}, 64'(m_last), 64'(0));
    chk({name, "_finish"}, 64'(axis_finish), 64'(0));
    chk({name, "_cnt"}, 64'(sample_cnt), 64'(0));
    chk({name, "_level"}, 64'(fifo_level), 64'(0));
    chk({name, "_len_err"}, 64'(len_err), 64'(0));
  endtask

  initial begin
    repeat (2) @(negedge clk);
    check_all_zero("reset");
    rst_n = 1'b1;
    cmp_en = 1'b1;
    @(negedge clk);

    // Traffic before ap_start is refused and not stored.
    s_tvalid = 1'b1;
    s_tdata  = 32'hDEAD;
    repeat (3) begin
      @(negedge clk);
      chk("prestart_ready", 64'(s_tready), 64'(0));
      chk("prestart_level", 64'(fifo_level), 64'(0));
    end
    s_tvalid = 1'b0;

    // Basic frame 1..8, tlast on 8; an ap_start mid-frame must be ignored.
    m_ready = 1'b1;
    rxq.delete();
    fin_cnt = 0;
    pulse_start();
    for (int i = 1; i <= 8; i++) begin
      if (i == 5) ap_start = 1'b1;
      send(32'(i), (i == 8));
      ap_start = 1'b0;
    end
    wait_idle();
    check_rx("basic", 1, 8);
    chk("basic_finish_pulses", 64'(fin_cnt), 64'(1));
    chk("basic_sample_cnt", 64'(sample_cnt), 64'(8));

    // Backpressure: 4 accepted then stall; full with simultaneous pop.
    m_ready = 1'b0;
    rxq.delete();
    fin_cnt = 0;
    pulse_start();
    for (int i = 11; i <= 14; i++) send(32'(i), 1'b0);
    s_tvalid = 1'b1;
    s_tdata  = 32'd15;
    repeat (2) @(negedge clk);
    chk("bp_ready_low", 64'(s_tready), 64'(0));
    chk("bp_level_full", 64'(fifo_level), 64'(4));
    chk("bp_cnt", 64'(sample_cnt), 64'(4));
    m_ready = 1'b1;
    @(negedge clk);
    chk("fullpop_level", 64'(fifo_level), 64'(3));
    chk("fullpop_ready_rise", 64'(s_tready), 64'(1));
    send(32'd15, 1'b0);
    send(32'd16, 1'b1);
    wait_idle();
    check_rx("bp", 11, 6);
    chk("bp_finish_pulses", 64'(fin_cnt), 64'(1));

    // Reset mid-frame after 3 of 8 samples.
    m_ready = 1'b0;
    pulse_start();
    for (int i = 21; i <= 23; i++) send(32'(i), 1'b0);
    chk("pre_reset_level", 64'(fifo_level), 64'(3));
    #1 rst_n = 1'b0;
    #1 check_all_zero("midreset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    m_ready = 1'b1;
    rxq.delete();
    fin_cnt = 0;
    pulse_start();
    for (int i = 31; i <= 33; i++) send(32'(i), (i == 33));
    wait_idle();
    check_rx("after_reset", 31, 3);
    chk("after_reset_cnt", 64'(sample_cnt), 64'(3));

`ifdef AXIS_IN_LEN_CHECK_EN
    // Early tlast: error flagged, frame still ends on tlast.
    data_length = 16'd5;
    rxq.delete();
    pulse_start();
    for (int i = 41; i <= 43; i++) send(32'(i), (i == 43));
    wait_idle();
    check_rx("short", 41, 3);
    chk("short_len_err", 64'(len_err), 64'(1));

    // Length reached without tlast: fifth sample forced last, frame truncated.
    rxq.delete();
    fin_cnt = 0;
    pulse_start();
    chk("len_err_cleared", 64'(len_err), 64'(0));
    for (int i = 51; i <= 55; i++) send(32'(i), 1'b0);
    s_tvalid = 1'b1;
    s_tdata  = 32'd56;
    repeat (2) begin
      @(negedge clk);
      chk("trunc_ready_low", 64'(s_tready), 64'(0));
    end
    s_tvalid = 1'b0;
    wait_idle();
    check_rx("trunc", 51, 5);
    chk("trunc_len_err", 64'(len_err), 64'(1));
    chk("trunc_finish_pulses", 64'(fin_cnt), 64'(1));
`else
    chk("len_err_tied", 64'(len_err), 64'(0));
`endif

    cmp_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected finish before 200000");
    $fatal(1);
  end

endmodule

// File: doc/axis_in_fifo.md
Name: axis_in_fifo

Overview:
Parametrised AXI-Stream ingress for the FIR dataflow; the successor to the single-register stream input stage. It accepts samples from the AXI-Stream slave port into a DEPTH-entry synchronous FIFO, carries tlast alongside each sample, and presents a registered valid/ready stream to the FIR core. It tracks the frame (ap_start to last sample consumed) and reports completion, sample count and FIFO level.

Parameters:
pDATA_WIDTH, 32, sample width in bits
pDEPTH, 4, FIFO entries; power of 2, minimum 2
pCNT_WIDTH, 16, width of sample counter and data_length

Ports:
clk  in  1  clock
rst_n  in  1  reset, asynchronous, active-low
ap_start  in  1  frame start pulse from control block
data_length  in  pCNT_WIDTH  expected samples per frame; used only with the length check
s_tvalid  in  1  AXIS slave valid
s_tdata  in  pDATA_WIDTH  AXIS slave data
s_tlast  in  1  AXIS slave last
s_tready  out  1  AXIS slave ready
m_valid  out  1  sample valid toward the FIR core
m_data  out  pDATA_WIDTH  sample toward the FIR core
m_last  out  1  marks the frame's final sample
m_ready  in  1  FIR core ready
axis_finish  out  1  one-cycle pulse when the last sample pops
sample_cnt  out  pCNT_WIDTH  samples accepted this frame
fifo_level  out  clog2(pDEPTH)+1  current FIFO occupancy
len_err  out  1  sticky frame-length error

Behaviour:
- Reset: state IDLE; FIFO empty; s_tready=0, m_valid=0, m_data=0, m_last=0, axis_finish=0, sample_cnt=0, fifo_level=0, len_err=0. Reset mid-frame discards FIFO contents immediately.
- FSM states: IDLE, RUN, DRAIN.
  - IDLE: s_tready=0. ap_start -> RUN; sample_cnt and len_err clear on the same edge.
  - RUN: s_tready = !full. On an accepted beat with s_tlast=1 -> DRAIN. ap_start is ignored.
  - DRAIN: s_tready=0. When the entry flagged last pops (m_valid & m_ready & m_last) -> IDLE.
- Push on s_tvalid & s_tready. Pop on m_valid & m_ready.
- Handshake coupling: s_tready is !full only. A push into a full FIFO is not allowed even when a pop happens in the same cycle, so there is no ready-to-ready combinational path.
- Simultaneous push and pop with FIFO not full: fifo_level unchanged; both pointers advance.
- Output stage: m_valid/m_data/m_last are driven from the FIFO head with first-word fall-through. Latency from accept edge to m_valid high is 1 cycle. m_data holds its value while m_valid & !m_ready.
- Pointers are clog2(pDEPTH)+1 bits and wrap naturally. full = MSBs differ and LSBs equal. empty = pointers equal.
- sample_cnt increments per push and saturates at all-ones.
- axis_finish is registered and asserted for exactly the one cycle after the last-flagged pop.

Optional Feature:
AXIS_IN_LEN_CHECK_EN
- Defined:
  - Accepted s_tlast while sample_cnt+1 < data_length -> len_err=1; frame still ends normally.
  - Push that makes sample_cnt == data_length without s_tlast -> len_err=1; that entry is stored with last=1 and the FSM enters DRAIN (frame is truncated).
  - len_err is sticky until the next ap_start.
- Undefined: data_length is unused; len_err is tied 0; s_tlast alone terminates the frame.

Decomposition:
- Package axis_in_pkg: FSM state localparams (IDLE/RUN/DRAIN, 2-bit), pointer-width function (clog2).
- One sub-module, axis_sync_fifo: storage of {last,data}, pointers, full/empty/level.
- FSM, counter and length check live in the top module.

Test Plan:
- Reset mid-frame: assert rst_n low after 3 of 8 samples accepted -> all outputs 0 immediately; next frame with ap_start starts cleanly.
- Basic frame: pDEPTH=4, ap_start, 8 samples 1..8, tlast on 8, m_ready=1 -> m_data 1..8 in order, each 1 cycle after accept; m_last on 8; axis_finish pulse 1 cycle later; sample_cnt=8.
- Backpressure: m_ready=0 while 6 samples are offered -> s_tready drops after 4 accepts, fifo_level=4; release m_ready -> 6 samples delivered in order, none lost or duplicated.
- Full with simultaneous pop: FIFO full, m_ready=1, s_tvalid=1 -> no push that cycle; s_tready rises the following cycle.
- Pre-start traffic: s_tvalid=1 with s_tdata=0xDEAD before ap_start -> s_tready=0, nothing is stored.
- Length check (macro on): data_length=5, tlast on sample 3 -> len_err=1 and frame ends. data_length=5, no tlast -> sample 5 emitted with m_last=1, len_err=1, s_tready=0 afterwards.
